// File: rtl/vsm_bus_arbiter.sv
// vsm_bus_arbiter
// Round-robin owner selection for the 4-bit internal bus IB of the VSM processor.
// Sources: bit 0 = input register (EnableIn), 1 = accumulator, 2 = ALU, 3 = memory.
// Grant is a registered one-hot set of tristate enables. Between two owners a dead
// interval of TURN_CYCLES cycles with all enables low keeps two bufif1 drivers
// from overlapping on IB.
//
// Handshake: req[i] is a level request. Requester i raises it and holds it high
// for as long as it needs IB. While grant[i] is high, source i may drive IB.
// Requester i releases the bus by dropping req[i], and grant[i] falls on the next
// edge. Requests from non-owners are only looked at on a re-arbitration edge.
//
// Optional feature macro: VSM_BUS_TIMEOUT_EN. When it is defined, an owner that has
// held IB for MAX_HOLD cycles while another requester waits is forced off the bus,
// and preempt pulses for one cycle. When it is undefined, there is no hold counter
// and preempt is constant 0.
//
// Debug: state exposes the FSM encoding (0 = IDLE, 1 = GRANT, 2 = TURN).

module vsm_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] bus_owner,
  output logic       busy,
  output logic       preempt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES - 1);
  localparam bit CFG_OK = (TURN_CYCLES >= 1) && (TURN_CYCLES <= 3) &&
                          (MAX_HOLD >= 2) && (MAX_HOLD <= 15);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [1:0] turn_q, turn_d;
  logic [1:0] winner;
  logic       timeout_hit;

  // Scan starts one past the last owner and wraps. The loop runs from the largest
  // offset down to 1, so the nearest requester is assigned last and wins. The
  // previous owner (offset 4) wins only when it is the only requester.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign winner = rr_pick(req, last_q);

`ifdef VSM_BUS_TIMEOUT_EN
  logic [3:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;

  // Timeout fires once the owner has used MAX_HOLD cycles and someone else is waiting.
  assign timeout_hit = (hold_q >= 4'(MAX_HOLD)) && ((req & ~grant_q) != 4'b0000);

  // Hold count: 1 on the first granted cycle, then saturating at 15. Cleared off-bus.
  // A release by the owner takes precedence over a coincident timeout.
  always_comb begin
    hold_d    = 4'd0;
    preempt_d = 1'b0;
    if (state_d == ST_GRANT) begin
      if (state_q == ST_GRANT) hold_d = (hold_q == 4'd15) ? hold_q : hold_q + 4'd1;
      else                     hold_d = 4'd1;
    end
    if ((state_q == ST_GRANT) && req[owner_q] && timeout_hit) preempt_d = 1'b1;
  end

  // Hold counter and preempt pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= 4'd0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  // State register plus the registered bus outputs. Reset clears grant at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      turn_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
    end
  end

  // Next-state logic: arbitrate from IDLE or at the end of TURN, release on drop or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req != 4'b0000) state_d = ST_GRANT;
      ST_GRANT: if (!req[owner_q] || timeout_hit) state_d = ST_TURN;
      ST_TURN:  if (turn_q == 2'd0) state_d = (req != 4'b0000) ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: compute the next registered grant, owner, last owner and turn count.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    turn_d  = turn_q;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_GRANT) begin
          grant_d = 4'b0001 << winner;
          owner_d = winner;
          last_d  = winner;
        end
      end
      ST_GRANT: begin
        if (state_d == ST_TURN) begin
          grant_d = 4'b0000;
          turn_d  = TURN_LOAD;
        end
      end
      ST_TURN: begin
        grant_d = 4'b0000;
        if (turn_q != 2'd0) begin
          turn_d = turn_q - 2'd1;
        end else if (state_d == ST_GRANT) begin
          grant_d = 4'b0001 << winner;
          owner_d = winner;
          last_d  = winner;
        end
      end
      default: grant_d = 4'b0000;
    endcase
  end

  assign grant     = grant_q;
  assign bus_owner = owner_q;
  assign busy      = (grant_q != 4'b0000);
  assign state     = state_q;

  // Two enables on IB at once would be a bus fight.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

  // Parameters must be inside their legal ranges.
  a_cfg_legal: assert property (@(posedge clk) CFG_OK);

endmodule

// File: tb/tb_vsm_bus_arbiter.sv
// Directed bench for vsm_bus_arbiter (TURN_CYCLES = 2, MAX_HOLD = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vsm_bus_arbiter;

  localparam int TURN = 2;
  localparam int HOLD = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  // Clock and reset
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] bus_owner;
  logic       busy;
  logic       preempt;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vsm_bus_arbiter #(.TURN_CYCLES(TURN), .MAX_HOLD(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant     (grant),
    .bus_owner (bus_owner),
    .busy      (busy),
    .preempt   (preempt),
    .state     (state)
  );

  // Driver: pulse reset for one cycle and leave all requests low.
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Driver: drop all requests and let the arbiter drain back to IDLE.
  task automatic settle();
    req = 4'b0000;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    repeat (2) @(negedge clk);
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (preempt !== 1'b0) begin n_err++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
    n_vec++; if (bus_owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got=%0d exp=0", bus_owner); end
    n_vec++; if (state !== S_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state); end
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL first_grant got=%b exp=0001", grant); end
    n_vec++; if (bus_owner !== 2'd0) begin n_err++; $display("FAIL first_owner got=%0d exp=0", bus_owner); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy got=%b exp=1", busy); end
    n_vec++; if (state !== S_GRANT) begin n_err++; $display("FAIL first_state got=%0d exp=1", state); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL release_grant got=%b exp=0000", grant); end
    n_vec++; if (state !== S_TURN) begin n_err++; $display("FAIL release_state got=%0d exp=2", state); end
    repeat (2) @(negedge clk);
    n_vec++; if (state !== S_IDLE) begin n_err++; $display("FAIL drain_state got=%0d exp=0", state); end
  endtask

  task automatic test_handover();
    int dead;
    apply_reset();
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL hold0_cyc%0d got=%b exp=0001", i, grant); end
    end
    req = 4'b0010;
    dead = 0;
    @(negedge clk);
    for (int k = 0; k < 10 && grant === 4'b0000; k++) begin
      dead++;
      @(negedge clk);
    end
    n_vec++; if (dead !== TURN) begin n_err++; $display("FAIL dead_cycles got=%0d exp=%0d", dead, TURN); end
    n_vec++; if (grant !== 4'b0010) begin n_err++; $display("FAIL handover_grant got=%b exp=0010", grant); end
    n_vec++; if (bus_owner !== 2'd1) begin n_err++; $display("FAIL handover_owner got=%0d exp=1", bus_owner); end
    settle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    apply_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        n_vec++; if (!$onehot0(grant)) begin n_err++; $display("FAIL rr_onehot got=%b exp=onehot0", grant); end
        if (grant !== 4'b0000) break;
        req = 4'b1111;
      end
      n_vec++; if (grant !== exp_g) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", g, grant, exp_g); end
      n_vec++; if (bus_owner !== 2'(g % 4)) begin n_err++; $display("FAIL rr_owner%0d got=%0d exp=%0d", g, bus_owner, g % 4); end
      req = 4'b1111 & ~grant;
    end
    settle();
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0101;
`ifdef VSM_BUS_TIMEOUT_EN
    for (int i = 0; i < HOLD; i++) begin
      @(negedge clk);
      n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL to_hold%0d got=%b exp=0001", i, grant); end
      n_vec++; if (preempt !== 1'b0) begin n_err++; $display("FAIL to_nopre%0d got=%b exp=0", i, preempt); end
    end
    @(negedge clk);
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL to_release got=%b exp=0000", grant); end
    n_vec++; if (preempt !== 1'b1) begin n_err++; $display("FAIL to_preempt got=%b exp=1", preempt); end
    @(negedge clk);
    n_vec++; if (preempt !== 1'b0) begin n_err++; $display("FAIL to_pulse got=%b exp=0", preempt); end
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL to_dead got=%b exp=0000", grant); end
    @(negedge clk);
    n_vec++; if (grant !== 4'b0100) begin n_err++; $display("FAIL to_next got=%b exp=0100", grant); end
    n_vec++; if (bus_owner !== 2'd2) begin n_err++; $display("FAIL to_owner got=%0d exp=2", bus_owner); end
    settle();
    apply_reset();
    req = 4'b0001;
`endif
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL keep_grant%0d got=%b exp=0001", i, grant); end
      n_vec++; if (preempt !== 1'b0) begin n_err++; $display("FAIL keep_preempt%0d got=%b exp=0", i, preempt); end
    end
    settle();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 4'b1000;
    @(negedge clk);
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL mid_pre got=%b exp=1000", grant); end
    n_vec++; if (bus_owner !== 2'd3) begin n_err++; $display("FAIL mid_owner got=%0d exp=3", bus_owner); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL mid_async_grant got=%b exp=0000", grant); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_async_busy got=%b exp=0", busy); end
    n_vec++; if (state !== S_IDLE) begin n_err++; $display("FAIL mid_async_state got=%0d exp=0", state); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (grant !== 4'b1000) begin n_err++; $display("FAIL mid_regrant got=%b exp=1000", grant); end
    n_vec++; if (bus_owner !== 2'd3) begin n_err++; $display("FAIL mid_reowner got=%0d exp=3", bus_owner); end
    settle();
  endtask

  task automatic test_turn_pulse();
    apply_reset();
    req = 4'b0001;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0001) begin n_err++; $display("FAIL tp_grant got=%b exp=0001", grant); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (state !== S_TURN) begin n_err++; $display("FAIL tp_turn got=%0d exp=2", state); end
    req = 4'b0100;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL tp_dead got=%b exp=0000", grant); end
    req = 4'b0000;
    @(negedge clk);
    n_vec++; if (grant !== 4'b0000) begin n_err++; $display("FAIL tp_nogrant got=%b exp=0000", grant); end
    n_vec++; if (state !== S_IDLE) begin n_err++; $display("FAIL tp_idle got=%0d exp=0", state); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tp_busy got=%b exp=0", busy); end
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    test_reset();
    test_handover();
    test_round_robin();
    test_timeout();
    test_reset_mid_grant();
    test_turn_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
